// File: rtl/jac1_run_monitor_if.sv
// Trace readout port of the JAC1 run monitor: pop request, popped data and fill level.
// Latency: rd_data/rd_valid follow rd_en by one cycle.
// Backpressure: none; a pop on an empty trace (or outside DONE) simply returns no rd_valid.
//
// Ports:
//   rd_en       reader -> monitor  pop request
//   rd_data     monitor -> reader  popped entry, held until the next pop
//   rd_valid    monitor -> reader  one-cycle pulse qualifying rd_data
//   trace_count monitor -> reader  number of unread entries (0..Depth)
interface jac1_run_monitor_if #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16
);
  logic                   rd_en;
  logic [DataWidth-1:0]   rd_data;
  logic                   rd_valid;
  logic [$clog2(Depth):0] trace_count;

  // master: the trace reader; slave: the run monitor
  modport master (output rd_en, input rd_data, input rd_valid, input trace_count);
  modport slave  (input rd_en, output rd_data, output rd_valid, output trace_count);
endinterface

// File: rtl/jac1_run_monitor.sv
// Run controller + trace recorder: resets the JAC1 core, runs it N cycles or until a value match, logs reg_val.
// Latency: core_res_n rises ResCycles+1 edges after start; trace pop data appears one cycle after rd_en.
// Backpressure: none; captures into a full trace are dropped (overflow flag), pops only honoured in DONE.
//
// Ports:
//   clk, sys_res                  clock and synchronous active-high reset
//   start, run_cycles, expect_val,
//   expect_en, on_change          run request and its configuration (latched at start)
//   reg_val                       core register value, sampled once per RUN cycle
//   core_res_n                    registered active-low reset to the core
//   busy, done, match, overflow   status flags (match/overflow sticky within a run)
//   trace                         readout interface (rd_en, rd_data, rd_valid, trace_count)
module jac1_run_monitor #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16,
  parameter int ResCycles = 1,
  parameter int CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 sys_res,
  input  logic                 start,
  input  logic [CntWidth-1:0]  run_cycles,
  input  logic [DataWidth-1:0] expect_val,
  input  logic                 expect_en,
  input  logic                 on_change,
  input  logic [DataWidth-1:0] reg_val,
  output logic                 core_res_n,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic                 overflow,
  jac1_run_monitor_if.slave    trace
);

  localparam int PtrW   = $clog2(Depth);
  localparam int CountW = PtrW + 1;
  localparam int HoldW  = $clog2(ResCycles + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state;
  logic [HoldW-1:0]     hold_cnt;
  logic [CntWidth-1:0]  run_cnt;
  logic [CntWidth-1:0]  run_cycles_q;
  logic [DataWidth-1:0] expect_val_q;
  logic                 expect_en_q;
  logic                 on_change_q;
  logic                 first_q;      // next RUN sample is the first of this run
  logic [DataWidth-1:0] last_val;     // last value actually written to the trace

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CountW-1:0]    count;
  logic [DataWidth-1:0] rd_data_q;
  logic                 rd_valid_q;

  logic launch;
  logic full;
  logic capture;
  logic hit;
  logic last_sample;

  always_comb begin
    launch      = start && ((state == S_IDLE) || (state == S_DONE));
    full        = (count == CountW'(Depth));
    capture     = !on_change_q || first_q || (reg_val != last_val);
    hit         = expect_en_q && (reg_val == expect_val_q);
    // run_cycles_q >= 1 whenever RUN is entered, so this never wraps below zero
    last_sample = ((run_cnt + CntWidth'(1)) == run_cycles_q);
  end

  always_ff @(posedge clk) begin
    if (sys_res) begin
      state        <= S_IDLE;
      core_res_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      match        <= 1'b0;
      overflow     <= 1'b0;
      hold_cnt     <= '0;
      run_cnt      <= '0;
      run_cycles_q <= '0;
      expect_val_q <= '0;
      expect_en_q  <= 1'b0;
      on_change_q  <= 1'b0;
      first_q      <= 1'b0;
      last_val     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (launch) begin
        // A start in DONE overrides a simultaneous pop.
        state        <= S_HOLD;
        core_res_n   <= 1'b0;
        busy         <= 1'b1;
        done         <= 1'b0;
        match        <= 1'b0;
        overflow     <= 1'b0;
        hold_cnt     <= HoldW'(ResCycles);
        run_cnt      <= '0;
        run_cycles_q <= run_cycles;
        expect_val_q <= expect_val;
        expect_en_q  <= expect_en;
        on_change_q  <= on_change;
        first_q      <= 1'b1;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
      end else begin
        case (state)
          S_HOLD: begin
            if (hold_cnt == HoldW'(1)) begin
              if (run_cycles_q == '0) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state      <= S_RUN;
                core_res_n <= 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt - HoldW'(1);
            end
          end
          S_RUN: begin
            run_cnt <= run_cnt + CntWidth'(1);
            first_q <= 1'b0;
            if (capture) begin
              if (full) begin
                overflow <= 1'b1;
              end else begin
                mem[wr_ptr] <= reg_val;
                wr_ptr      <= wr_ptr + PtrW'(1);
                count       <= count + CountW'(1);
                last_val    <= reg_val;
              end
            end
            if (hit) begin
              match <= 1'b1;
            end
            if (hit || last_sample) begin
              state      <= S_DONE;
              core_res_n <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
          S_DONE: begin
            if (trace.rd_en && (count != '0)) begin
              rd_data_q  <= mem[rd_ptr];
              rd_valid_q <= 1'b1;
              rd_ptr     <= rd_ptr + PtrW'(1);
              count      <= count - CountW'(1);
            end
          end
          default: begin
            // IDLE: wait for start
          end
        endcase
      end
    end
  end

  assign trace.rd_data     = rd_data_q;
  assign trace.rd_valid    = rd_valid_q;
  assign trace.trace_count = count;

endmodule

// File: doc/jac1_run_monitor.md
# jac1_run_monitor

Synthesizable run controller and trace recorder for the JAC1 core. It sequences the core's active-low reset, lets the core run for a programmed number of cycles or until a target register value appears, and records the core's `reg_val` output into an on-chip trace buffer for later readout. It is the parametrised successor of the fixed-length simulation run sequence: width, trace depth, run length, capture mode and stop-on-match are all configurable. It sits between the system clock/reset and a `JAC1_Top` instance, with `core_res_n` driving the core's `sys_res_n` and `reg_val` fed back from it.

## Interface
- `DataWidth`, 8: width of `reg_val`, `expect_val` and `rd_data`.
- `Depth`, 16: trace entries; power of two, at least 2.
- `ResCycles`, 1: cycles the core is held in reset before each run; at least 1.
- `CntWidth`, 16: width of `run_cycles` and the run counter.

- `clk`  in  1  system clock; all logic on the rising edge.
- `sys_res`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle run request; honoured only in IDLE or DONE.
- `run_cycles`  in  CntWidth  maximum RUN cycles; latched at start.
- `expect_val`  in  DataWidth  stop value; latched at start.
- `expect_en`  in  1  enables stop-on-match; latched at start.
- `on_change`  in  1  capture mode: 0 captures every cycle, 1 captures on change; latched at start.
- `reg_val`  in  DataWidth  core register value.
- `core_res_n`  out  1  registered active-low reset to the core.
- `busy`  out  1  high in HOLD and RUN.
- `done`  out  1  high in DONE.
- `match`  out  1  sticky; set when the expected value is seen.
- `overflow`  out  1  sticky; set when a capture is dropped because the trace is full.
- `trace_count`  out  $clog2(Depth)+1  number of unread entries.
- `rd_en`  in  1  trace pop request.
- `rd_data`  out  DataWidth  popped entry; holds until the next pop.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_data`.

## Operation
- The FSM has four states: IDLE, HOLD, RUN and DONE. All outputs are registered.
- Reset (`sys_res`=1) produces the following next-edge state, including when asserted mid-run:
  - state IDLE, `core_res_n`=0
  - `busy`=`done`=`match`=`overflow`=0
  - `trace_count`=0, `rd_data`=0, `rd_valid`=0
  - the trace is emptied.
- IDLE to HOLD on `start`=1. The same edge:
  - latches the configuration inputs
  - clears the trace, `match` and `overflow`
  - loads the hold counter with ResCycles.
- HOLD:
  - `core_res_n`=0 for exactly ResCycles cycles.
  - If the latched `run_cycles`=0, the next state is DONE with an empty trace. Otherwise it is RUN, with `core_res_n`=1 in the first RUN cycle.
- RUN:
  - Each RUN cycle samples `reg_val` once and increments the run counter.
  - Capture when `on_change`=0: every sample is written.
  - Capture when `on_change`=1: the first RUN sample is always written; later samples are written only if they differ from the last written value.
  - A write with `trace_count`=Depth is dropped and sets `overflow`. Entries are never overwritten.
  - If `expect_en`=1 and sample == `expect_val`, `match` is set. That sample is captured normally, and the next state is DONE.
  - Otherwise, the next state after the run_cycles-th RUN sample is DONE.
  - `start` is ignored in HOLD and RUN.
- DONE:
  - `core_res_n`=0 (the core is held in reset), `busy`=0, `done`=1.
  - The trace is read FIFO order, oldest first.
  - `rd_en`=1 with `trace_count`>0 pops one entry: `rd_data` and `rd_valid`=1 appear the next cycle, and `trace_count` decrements on the same edge.
  - `rd_en` with `trace_count`=0 is ignored and gives `rd_valid`=0.
  - `rd_en` in any other state is ignored.
  - `start` in DONE begins a new run exactly as from IDLE. If `rd_en` and `start` are both high, `start` wins and no pop occurs.
- Counter arithmetic:
  - Read and write pointers are log2(Depth) bits wide and wrap modulo Depth.
  - `trace_count` saturates at Depth.
  - The run counter compares at full CntWidth, giving at most 2^CntWidth−1 RUN cycles.

## Timing
- `start` at edge N:
  - `busy`=1 from N+1.
  - `core_res_n` rises at edge N+1+ResCycles.
- First sample: the value on `reg_val` in the cycle after `core_res_n` rises, which is the core's first post-reset output.
- Run length: with no match, exactly `run_cycles` RUN cycles. DONE and `core_res_n`=0 occur at the edge after the last sample.
- Match at sample k: DONE occurs at the next edge. No further samples are taken.
- Read latency is 1 cycle. Back-to-back `rd_en` gives one entry per cycle.

## Test plan
- **Reset values:** assert `sys_res` for 2 cycles → all outputs 0; `core_res_n`=0; `rd_en` gives no `rd_valid`.
- **Fixed run:** ResCycles=1, `run_cycles`=8, `on_change`=0, `reg_val` counting 0..7 → `core_res_n` low 1 cycle then high 8 cycles; `done`; `trace_count`=8; eight pops read 0..7; `match`=0; `overflow`=0.
- **Stop on match:** `expect_en`=1, `expect_val`=8'h05, `reg_val` counting from 0, `run_cycles`=100 → `match`=1; DONE after 6 samples; trace reads 0..5.
- **Overflow:** Depth=16, `run_cycles`=20, every-cycle capture → `trace_count`=16; `overflow`=1; pops read samples 0..15 in order; a 17th `rd_en` gives no `rd_valid`.
- **Change mode:** `on_change`=1 with `reg_val` sequence 3,3,3,7,7,3 → trace 3,7,3; `trace_count`=3.
- **Reset mid-run and restart:** `sys_res` asserted in RUN → IDLE next edge with all outputs at reset values. Then `start` with `run_cycles`=0 → HOLD then DONE; `trace_count`=0. Then `start` from DONE while `rd_en`=1 → new run begins and no pop occurs.
